// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN frame sequencer.
// The image and kernel geometry is fixed here and shared by the
// controller, its raster counter and the bus interface.
package cnn_pkg;

    localparam int I_F_BW = 8;
    localparam int IX     = 28;
    localparam int IY     = 28;
    localparam int KX     = 5;
    localparam int KY     = 5;

    localparam int OUT_W  = IX - KX + 1;
    localparam int OUT_H  = IY - KY + 1;
    localparam int N_PIX  = IX * IY;
    localparam int N_OUT  = OUT_W * OUT_H;
    localparam int AW     = $clog2(N_PIX);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE,
        ERR
    } ctrl_state_t;

endpackage

// File: rtl/cnn_frame_ctrl_if.sv
// Handshake and data bus between the start/handshake logic, the image
// RAM, the CNN core and the frame sequencer.
// slave is the sequencer side, master is the environment side.
interface cnn_frame_ctrl_if
    import cnn_pkg::*;
#(
    parameter int PW = I_F_BW,
    parameter int AWID = AW
);

    logic            i_start;
    logic            i_ready;
    logic            o_img_rd_en;
    logic [AWID-1:0] o_img_addr;
    logic [PW-1:0]   i_img_data;
    logic [PW-1:0]   o_pixel;
    logic            o_pixel_valid;
    logic            o_win_valid;
    logic            i_core_valid;
    logic            o_busy;
    logic            o_done;
    logic            o_error;

    modport slave (
        input  i_start, i_ready, i_img_data, i_core_valid,
        output o_img_rd_en, o_img_addr, o_pixel, o_pixel_valid,
               o_win_valid, o_busy, o_done, o_error
    );

    modport master (
        output i_start, i_ready, i_img_data, i_core_valid,
        input  o_img_rd_en, o_img_addr, o_pixel, o_pixel_valid,
               o_win_valid, o_busy, o_done, o_error
    );

endinterface

// File: rtl/cnn_raster_cnt.sv
// Raster-order column/row counter for the image fetch.
// Flags the last pixel of the frame and whether the current position
// completes a full kernel window (bottom-right corner of a window).
module cnn_raster_cnt
    import cnn_pkg::*;
#(
    parameter int RW = $clog2(IY),
    parameter int CW = $clog2(IX)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o,
    output logic win_o
);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    assign last_o = (row_q == RW'(IY - 1)) && (col_q == CW'(IX - 1));
    assign win_o  = (row_q >= RW'(KY - 1)) && (col_q >= CW'(KX - 1));

    // Next position: clear wins over enable; wrap col at row end and row at frame end
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (col_q == CW'(IX - 1)) begin
                col_d = '0;
                row_d = last_o ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Position registers
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/cnn_frame_ctrl.sv
// Frame sequencer: streams the image RAM into the CNN core in raster
// order, tags window-completing pixels, counts core results and ends
// the frame with a done pulse or an error pulse on drain timeout.
module cnn_frame_ctrl
    import cnn_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input logic             clk,
    input logic             reset,
    cnn_frame_ctrl_if.slave bus
);

    localparam int CNTW = $clog2(N_OUT + 1);
    localparam int TW   = $clog2(TIMEOUT);

    ctrl_state_t     state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [CNTW-1:0] out_cnt_q, out_cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            pix_valid_q;
    logic            win_valid_q;

    logic            issue;
    logic            start_clr;
    logic            last_pix;
    logic            win_pix;
    logic            cnt_inc;

    assign issue   = (state_q == FETCH) && bus.i_ready;
    assign cnt_inc = ((state_q == FETCH) || (state_q == DRAIN)) && bus.i_core_valid
                     && (out_cnt_q != CNTW'(N_OUT));

    cnn_raster_cnt u_raster (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (start_clr),
        .en_i   (issue),
        .last_o (last_pix),
        .win_o  (win_pix)
    );

    assign bus.o_img_rd_en   = issue;
    assign bus.o_img_addr    = addr_q;
    assign bus.o_pixel_valid = pix_valid_q;
    assign bus.o_pixel       = pix_valid_q ? bus.i_img_data : '0;
    assign bus.o_win_valid   = win_valid_q;
    assign bus.o_busy        = (state_q == FETCH) || (state_q == DRAIN);
    assign bus.o_done        = (state_q == DONE);
    assign bus.o_error       = (state_q == ERR);

    // Next-state logic: fetch sequencing, result counting and drain timeout
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        out_cnt_d = cnt_inc ? out_cnt_q + CNTW'(1) : out_cnt_q;
        tmo_d     = tmo_q;
        start_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d   = FETCH;
                    addr_d    = '0;
                    out_cnt_d = '0;
                    tmo_d     = '0;
                    start_clr = 1'b1;
                end
            end
            FETCH: begin
                if (issue) begin
                    if (last_pix) begin
                        addr_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                tmo_d = bus.i_core_valid ? '0 : tmo_q + TW'(1);
                if (out_cnt_d == CNTW'(N_OUT)) begin
                    state_d = DONE;
                end else if (!bus.i_core_valid && (tmo_q == TW'(TIMEOUT - 1))) begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counters and the one-cycle pixel/window qualifiers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            out_cnt_q   <= '0;
            tmo_q       <= '0;
            pix_valid_q <= 1'b0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            out_cnt_q   <= out_cnt_d;
            tmo_q       <= tmo_d;
            pix_valid_q <= issue;
            win_valid_q <= issue && win_pix;
        end
    end

endmodule

// File: tb/tb_cnn_frame_ctrl.sv
// Scoreboard bench for cnn_frame_ctrl: a frame start pushes the expected
// address, pixel and end-event streams; monitor processes pop and compare.
module tb_cnn_frame_ctrl;
    import cnn_pkg::*;

    localparam int TB_TIMEOUT = 64;
    localparam int CORE_LAT   = 3;
    localparam int EV_DONE    = 1;
    localparam int EV_ERR     = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cycle = 0;

    int checks = 0;
    int errors = 0;

    int addrQ[$];
    int pixQ[$];
    int evQ[$];
    int schedQ[$];

    int  pixCount;
    int  winCount;
    int  firstWinIdx;
    int  endSeen;
    int  winSeen;
    int  resultsSent;
    int  lastResultCycle;
    int  coreLimit;
    bit  coreTie;
    logic [7:0] ramData = '0;

    cnn_frame_ctrl_if bus ();

    cnn_frame_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [7:0] ramVal(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    // Synchronous image RAM model: data one cycle after the read enable
    always @(posedge clk) begin
        if (bus.o_img_rd_en) ramData <= ramVal(int'(bus.o_img_addr));
    end
    assign bus.i_img_data = ramData;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Core model: one result CORE_LAT cycles after each window pixel, up to
    // coreLimit results; in tie mode the final result is held back until the
    // drain timeout counter sits at its terminal count
    always @(negedge clk) begin
        if (bus.o_win_valid) begin
            winSeen++;
            if (winSeen <= coreLimit) schedQ.push_back(cycle + CORE_LAT);
        end
        bus.i_core_valid = 1'b0;
        if (schedQ.size() != 0 && schedQ[0] <= cycle) begin
            if (!(coreTie && resultsSent == N_OUT - 1) ||
                cycle >= lastResultCycle + TB_TIMEOUT) begin
                bus.i_core_valid = 1'b1;
                void'(schedQ.pop_front());
                resultsSent++;
                lastResultCycle = cycle;
            end
        end
    end

    // Monitor: pops expected issue addresses, pixels and end events
    always @(negedge clk) begin
        int exp;
        int evExp;
        if (!reset) begin
            if (bus.o_img_rd_en) begin
                if (addrQ.size() == 0) checkOutput("unexpected issue addr", int'(bus.o_img_addr), -1);
                else checkOutput("issue addr", int'(bus.o_img_addr), addrQ.pop_front());
            end
            if (bus.o_pixel_valid) begin
                if (pixQ.size() == 0) begin
                    checkOutput("unexpected pixel", int'(bus.o_pixel), -1);
                end else begin
                    exp = pixQ.pop_front();
                    checkOutput("pixel data", int'(bus.o_pixel), exp & 255);
                    checkOutput("win flag", int'(bus.o_win_valid), exp >> 8);
                end
                if (bus.o_win_valid) begin
                    winCount++;
                    if (firstWinIdx < 0) firstWinIdx = pixCount;
                end
                pixCount++;
            end else if (bus.o_win_valid) begin
                checkOutput("win without pixel", 1, 0);
            end
            if (bus.o_done || bus.o_error) begin
                checkOutput("busy during end pulse", int'(bus.o_busy), 0);
                evExp = (evQ.size() == 0) ? 0 : evQ.pop_front();
                checkOutput("end event", int'({bus.o_error, bus.o_done}), evExp);
                if (bus.o_error)
                    checkOutput("error timing", cycle, lastResultCycle + TB_TIMEOUT + 1);
                endSeen++;
            end
        end
    end

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " rd_en"}, int'(bus.o_img_rd_en), 0);
        checkOutput({tag, " addr"}, int'(bus.o_img_addr), 0);
        checkOutput({tag, " pixel"}, int'(bus.o_pixel), 0);
        checkOutput({tag, " pixel_valid"}, int'(bus.o_pixel_valid), 0);
        checkOutput({tag, " win_valid"}, int'(bus.o_win_valid), 0);
        checkOutput({tag, " busy"}, int'(bus.o_busy), 0);
        checkOutput({tag, " done"}, int'(bus.o_done), 0);
        checkOutput({tag, " error"}, int'(bus.o_error), 0);
    endtask

    // One frame: readyMode 0 = always ready, 1 = random 50%; pokeStart
    // reasserts start in FETCH and DRAIN; abortAddr >= 0 resets mid-frame
    task automatic applyStimulus(input int readyMode, input bit pokeStart, input int limit,
                                 input bit tie, input int abortAddr, input int expEv);
        int  budget;
        bit  aborted;
        bit  pokedDrain;
        coreLimit   = limit;
        coreTie     = tie;
        winSeen     = 0;
        resultsSent = 0;
        pixCount    = 0;
        winCount    = 0;
        firstWinIdx = -1;
        endSeen     = 0;
        schedQ.delete();
        for (int r = 0; r < IY; r++) begin
            for (int c = 0; c < IX; c++) begin
                addrQ.push_back(r * IX + c);
                pixQ.push_back(int'(ramVal(r * IX + c)) + ((r >= KY - 1 && c >= KX - 1) ? 256 : 0));
            end
        end
        if (expEv != 0) evQ.push_back(expEv);

        @(posedge clk); #1;
        bus.i_start = 1'b1;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        checkOutput("busy after start", int'(bus.o_busy), 1);

        budget     = 0;
        aborted    = 1'b0;
        pokedDrain = 1'b0;
        while (endSeen == 0 && !aborted && budget < 5000) begin
            bus.i_ready = (readyMode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.i_start = 1'b0;
            if (pokeStart && budget == 50) bus.i_start = 1'b1;
            if (pokeStart && !pokedDrain && bus.o_busy && addrQ.size() == 0) begin
                bus.i_start = 1'b1;
                pokedDrain  = 1'b1;
            end
            if (abortAddr >= 0) begin
                #1;
                if (bus.o_img_rd_en && int'(bus.o_img_addr) == abortAddr) begin
                    aborted = 1'b1;
                    reset   = 1'b1;
                end
            end
            if (!aborted) begin
                @(posedge clk); #1;
                budget++;
            end
        end
        bus.i_start = 1'b0;

        if (aborted) begin
            @(posedge clk); #1;
            reset = 1'b0;
            checkIdleOutputs("after abort");
            addrQ.delete();
            pixQ.delete();
            evQ.delete();
            schedQ.delete();
            coreLimit = 0;
            repeat (5) @(posedge clk);
            #1;
        end else begin
            if (endSeen == 0) checkOutput("frame end timeout", budget, -1);
            checkOutput("busy after end", int'(bus.o_busy), 0);
            checkOutput("done single pulse", int'(bus.o_done), 0);
            repeat (4) @(posedge clk);
            #1;
            checkOutput("pixel count", pixCount, N_PIX);
            checkOutput("window count", winCount, N_OUT);
            checkOutput("first window addr", firstWinIdx, 116);
            checkOutput("addr queue drained", addrQ.size(), 0);
            checkOutput("pixel queue drained", pixQ.size(), 0);
            checkOutput("end event count", endSeen, 1);
            addrQ.delete();
            pixQ.delete();
            evQ.delete();
        end
    endtask

    initial begin
        bus.i_start      = 1'b0;
        bus.i_ready      = 1'b0;
        bus.i_core_valid = 1'b0;
        coreLimit        = 0;
        coreTie          = 1'b0;
        lastResultCycle  = 0;
        reset            = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] frame with core always ready");
        applyStimulus(0, 1'b0, N_OUT, 1'b0, -1, EV_DONE);
        $display("[TB] frame with random ready");
        applyStimulus(1, 1'b0, N_OUT, 1'b0, -1, EV_DONE);
        $display("[TB] frame with start reasserted in FETCH and DRAIN");
        applyStimulus(0, 1'b1, N_OUT, 1'b0, -1, EV_DONE);
        $display("[TB] frame with one result missing");
        applyStimulus(0, 1'b0, N_OUT - 1, 1'b0, -1, EV_ERR);
        $display("[TB] frame aborted by reset at addr 300");
        applyStimulus(0, 1'b0, N_OUT, 1'b0, 300, 0);
        $display("[TB] frame after abort");
        applyStimulus(0, 1'b0, N_OUT, 1'b0, -1, EV_DONE);
        $display("[TB] last result on timeout terminal count");
        applyStimulus(0, 1'b0, N_OUT, 1'b1, -1, EV_DONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_frame_ctrl.md
Name: cnn_frame_ctrl

Overview:
- Frame sequencer for the single-channel CNN datapath (28x28 8-bit image, 5x5 kernel, 3 output channels).
- On a start pulse it reads the image from a synchronous image RAM in raster order and streams pixels into the core's line buffer.
- It flags which pixels complete a valid 5x5 window, counts the core's output results, and reports done, or error on timeout.
- Sits between the top-level start/handshake logic and cnn_top's pixel input.

Parameters:
- I_F_BW, 8, pixel width
- IX, 28, image width
- IY, 28, image height
- KX, 5, kernel width
- KY, 5, kernel height
- TIMEOUT, 4096, max cycles in DRAIN without a result before error
- derived: OUT_W=IX-KX+1, OUT_H=IY-KY+1, N_PIX=IX*IY, N_OUT=OUT_W*OUT_H, AW=$clog2(N_PIX)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_start  in  1  single-cycle frame start request
- i_ready  in  1  core can accept a pixel issued this cycle
- o_img_rd_en  out  1  image RAM read enable
- o_img_addr  out  AW  image RAM address
- i_img_data  in  I_F_BW  RAM read data, valid 1 cycle after o_img_rd_en
- o_pixel  out  I_F_BW  pixel to core
- o_pixel_valid  out  1  o_pixel valid this cycle
- o_win_valid  out  1  qualifies o_pixel as completing a full KYxKX window
- i_core_valid  in  1  core produced one output fmap (all CO channels)
- o_busy  out  1  high from accepted start until done/error
- o_done  out  1  one-cycle pulse, frame complete
- o_error  out  1  one-cycle pulse, DRAIN timeout

Behaviour:
- Reset: all outputs 0; state IDLE; addr, row, col, out_cnt, timeout counter 0. Reset mid-frame aborts immediately, with no done or error pulse.
- States: IDLE, FETCH, DRAIN, DONE, ERR.
- IDLE: if i_start, go to FETCH, assert o_busy next cycle, clear counters. i_start in any other state is ignored.
- FETCH: each cycle with i_ready=1, assert o_img_rd_en with o_img_addr=row*IX+col, then advance col. At col=IX-1, col wraps to 0 and row increments.
  - i_ready=0: rd_en=0; address and row/col hold.
  - After the issue at addr N_PIX-1, go to DRAIN.
- Pixel path, latency exactly 1 cycle:
  - o_pixel_valid = registered rd_en.
  - o_pixel = i_img_data, passed combinationally but qualified by o_pixel_valid.
  - o_win_valid = registered (rd_en && row>=KY-1 && col>=KX-1), using row/col of the issued address.
  - The core must consume every pixel it was ready for one cycle earlier. No retraction.
- Output counting: out_cnt increments on each i_core_valid in FETCH or DRAIN, saturating at N_OUT. i_core_valid in IDLE/DONE/ERR is ignored.
- DRAIN: when out_cnt reaches N_OUT (including the same-cycle increment), go to DONE.
  - Timeout counter resets on each i_core_valid and increments otherwise.
  - At TIMEOUT-1 with no result, go to ERR.
  - Reaching N_OUT and timeout in the same cycle: DONE wins.
- DONE: o_done=1 for one cycle, o_busy drops, then IDLE. ERR is the same, but pulses o_error.
- o_busy=1 in FETCH and DRAIN.
- Widths: row $clog2(IY), col $clog2(IX), out_cnt $clog2(N_OUT+1), timeout $clog2(TIMEOUT).

Decomposition:
- Package cnn_pkg holds:
  - IX, IY, KX, KY, I_F_BW, OUT_W, OUT_H, N_PIX, N_OUT localparams
  - state enum ctrl_state_t {IDLE, FETCH, DRAIN, DONE, ERR}
- One sub-module, cnn_raster_cnt: col/row counter with enable, clear, wrap, a last-pixel flag and a window-complete flag.

Test Plan:
- Start pulse, i_ready=1, core model asserts i_core_valid after each o_win_valid:
  - o_img_addr runs 0..783, with 784 o_pixel_valid pulses.
  - First o_win_valid is on addr 116 (row 4, col 4); 576 o_win_valid total.
  - o_done pulses once after the 576th result; o_busy low the cycle after.
- i_ready toggled in a pseudo-random 50% pattern:
  - Addresses stay contiguous, with no duplicates or gaps.
  - o_pixel equals RAM[addr] one cycle after issue.
  - o_win_valid count is still 576.
- i_start reasserted in FETCH and DRAIN -> no restart, addresses continue monotonically, a single o_done.
- Core model stops after 575 results, TIMEOUT=64 -> o_error pulses 64 cycles after the last result, o_done never asserts, o_busy drops.
- Reset asserted at addr 300 -> next cycle all outputs 0; a new start restarts at addr 0 with no done/error from the aborted frame.
- 576th i_core_valid on the same cycle as the timeout terminal count -> o_done, not o_error.
